// File: rtl/mem_stage_mc.sv
// Multi-cycle MEM stage: one load/store at a time, held request on a variable-latency data port.
// Latency: accept cycle + ACCESS until mem_resp + one DONE cycle (stall high N+2 cycles).
// Backpressure: stall freezes upstream while an access is outstanding; DONE never accepts a new entry.
module mem_stage_mc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BYTES  = DATA_W/8,
  parameter int LANE_W = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BYTES-1:0]  mem_byte_enable,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              req_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_nx;

  logic [1:0]        sz;
  logic [LANE_W-1:0] lane;
  logic              mem_op;
  logic              bad_size;
  logic              bad_align;
  logic              illegal;
  logic              accept;
  logic [2:0]        align_mask;
  logic [7:0]        be_base;
  logic [BYTES-1:0]  be_c;
  logic [DATA_W-1:0] wdata_c;

  logic [ADDR_W-1:0] addr_q;
  logic [LANE_W-1:0] lane_q;
  logic [2:0]        f3_q;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTES-1:0]  be_q;
  logic [DATA_W-1:0] ld_data_q;
  logic              err_q;

  logic [DATA_W-1:0] rdata_sh;
  logic [DATA_W-1:0] ld_ext;

  assign sz     = req_funct3[1:0];
  assign lane   = req_addr[LANE_W-1:0];
  assign mem_op = req_read | req_write;

  // Decode legality, alignment and the lane mask of the incoming request.
  always_comb begin
    bad_size = 1'b0;
    if (req_read && !req_write) begin
      if (req_funct3 == 3'b111) bad_size = 1'b1;
      if ((DATA_W == 32) && ((req_funct3 == 3'b110) || (sz == 2'd3))) bad_size = 1'b1;
    end else if (req_write && !req_read) begin
      if (req_funct3[2] || ((DATA_W == 32) && (sz == 2'd3))) bad_size = 1'b1;
    end

    case (sz)
      2'd0:    begin align_mask = 3'b000; be_base = 8'h01; end
      2'd1:    begin align_mask = 3'b001; be_base = 8'h03; end
      2'd2:    begin align_mask = 3'b011; be_base = 8'h0F; end
      default: begin align_mask = 3'b111; be_base = 8'hFF; end
    endcase

    bad_align = |(req_addr[2:0] & align_mask);
    // Read and write together is never a valid op, whatever funct3 says.
    illegal   = bad_size | bad_align | (req_read & req_write);
    be_c      = BYTES'(be_base) << lane;
    wdata_c   = req_wdata << {lane, 3'b000};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, upstream stall and accept strobe.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && mem_op && !illegal) begin
          accept   = 1'b1;
          stall    = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_resp) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the request so the memory port stays stable for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      addr_q  <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
      lane_q  <= lane;
      f3_q    <= req_funct3;
      rd_q    <= req_read;
      wr_q    <= req_write;
      wdata_q <= wdata_c;
      be_q    <= be_c;
    end
  end

  // Align the returned beat to bit 0 and extend per the load flavour.
  always_comb begin
    rdata_sh = mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = DATA_W'($signed(rdata_sh[7:0]));
      3'b001:  ld_ext = DATA_W'($signed(rdata_sh[15:0]));
      3'b010:  ld_ext = DATA_W'($signed(rdata_sh[31:0]));
      3'b100:  ld_ext = DATA_W'(rdata_sh[7:0]);
      3'b101:  ld_ext = DATA_W'(rdata_sh[15:0]);
      3'b110:  ld_ext = DATA_W'(rdata_sh[31:0]);
      default: ld_ext = rdata_sh;
    endcase
  end

  // Load result is captured on the response and held until the next load completes.
  always_ff @(posedge clk) begin
    if (rst)                                      ld_data_q <= '0;
    else if ((state == ACCESS) && mem_resp && rd_q) ld_data_q <= ld_ext;
  end

  // Rejected requests report one cycle after they are presented.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state == IDLE) && req_valid && mem_op && illegal;
  end

  assign mem_addr        = addr_q;
  assign mem_read        = (state == ACCESS) && rd_q;
  assign mem_write       = (state == ACCESS) && wr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;
  assign ld_data         = ld_data_q;
  assign ld_valid        = (state == DONE) && rd_q;
  assign req_err         = err_q;

endmodule

// File: tb/tb_mem_stage_mc.sv
module tb_mem_stage_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 32-bit instance
  logic        a_rst, a_req_valid, a_req_read, a_req_write, a_mem_resp;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata, a_mem_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_ld_data;
  logic [3:0]  a_mem_byte_enable;
  logic        a_mem_read, a_mem_write, a_stall, a_ld_valid, a_req_err;

  // 64-bit instance
  logic        b_rst, b_req_valid, b_req_read, b_req_write, b_mem_resp;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_mem_addr;
  logic [63:0] b_req_wdata, b_mem_rdata, b_mem_wdata, b_ld_data;
  logic [7:0]  b_mem_byte_enable;
  logic        b_mem_read, b_mem_write, b_stall, b_ld_valid, b_req_err;

  mem_stage_mc #(.DATA_W(32), .ADDR_W(32)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_read(a_req_read),
    .req_write(a_req_write), .req_funct3(a_req_funct3), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .mem_addr(a_mem_addr), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .mem_wdata(a_mem_wdata), .mem_byte_enable(a_mem_byte_enable),
    .mem_resp(a_mem_resp), .mem_rdata(a_mem_rdata), .stall(a_stall),
    .ld_data(a_ld_data), .ld_valid(a_ld_valid), .req_err(a_req_err)
  );

  mem_stage_mc #(.DATA_W(64), .ADDR_W(32)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_read(b_req_read),
    .req_write(b_req_write), .req_funct3(b_req_funct3), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .mem_addr(b_mem_addr), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_wdata(b_mem_wdata), .mem_byte_enable(b_mem_byte_enable),
    .mem_resp(b_mem_resp), .mem_rdata(b_mem_rdata), .stall(b_stall),
    .ld_data(b_ld_data), .ld_valid(b_ld_valid), .req_err(b_req_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, answers the memory n cycles into ACCESS, and records what was seen.
  task automatic a_access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int n,
                          input logic [31:0] rdata,
                          output int stall_cyc, output int ld_cnt, output int err_cnt,
                          output int req_cyc, output logic [31:0] ld_seen,
                          output logic [31:0] m_addr, output logic [3:0] m_be,
                          output logic [31:0] m_wd, output logic m_rd, output logic m_wr,
                          output int unstable);
    int acc;
    stall_cyc = 0; ld_cnt = 0; err_cnt = 0; acc = 0; unstable = 0;
    ld_seen = '0; m_addr = '0; m_be = '0; m_wd = '0; m_rd = 1'b0; m_wr = 1'b0;
    a_req_valid = 1'b1; a_req_read = rd; a_req_write = wr; a_req_funct3 = f3;
    a_req_addr = addr; a_req_wdata = wd;
    #1;
    for (int c = 0; c < n + 6; c++) begin
      if (a_stall) stall_cyc++;
      if (a_ld_valid) begin ld_cnt++; ld_seen = a_ld_data; end
      if (a_req_err) err_cnt++;
      if (a_mem_read || a_mem_write) begin
        if (acc == 0) begin
          m_addr = a_mem_addr; m_be = a_mem_byte_enable; m_wd = a_mem_wdata;
          m_rd = a_mem_read; m_wr = a_mem_write;
        end else if (a_mem_addr !== m_addr || a_mem_byte_enable !== m_be ||
                     a_mem_wdata !== m_wd || a_mem_read !== m_rd || a_mem_write !== m_wr) begin
          unstable++;
        end
        if (acc == n) begin a_mem_resp = 1'b1; a_mem_rdata = rdata; end
        acc++;
      end
      tick();
      a_req_valid = 1'b0; a_mem_resp = 1'b0; a_mem_rdata = '0;
      #1;
    end
    req_cyc = acc;
  endtask

  task automatic b_access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [63:0] wd, input int n,
                          input logic [63:0] rdata,
                          output int stall_cyc, output int ld_cnt, output int err_cnt,
                          output int req_cyc, output logic [63:0] ld_seen,
                          output logic [31:0] m_addr, output logic [7:0] m_be,
                          output logic [63:0] m_wd, output logic m_wr);
    int acc;
    stall_cyc = 0; ld_cnt = 0; err_cnt = 0; acc = 0;
    ld_seen = '0; m_addr = '0; m_be = '0; m_wd = '0; m_wr = 1'b0;
    b_req_valid = 1'b1; b_req_read = rd; b_req_write = wr; b_req_funct3 = f3;
    b_req_addr = addr; b_req_wdata = wd;
    #1;
    for (int c = 0; c < n + 6; c++) begin
      if (b_stall) stall_cyc++;
      if (b_ld_valid) begin ld_cnt++; ld_seen = b_ld_data; end
      if (b_req_err) err_cnt++;
      if (b_mem_read || b_mem_write) begin
        if (acc == 0) begin
          m_addr = b_mem_addr; m_be = b_mem_byte_enable; m_wd = b_mem_wdata; m_wr = b_mem_write;
        end
        if (acc == n) begin b_mem_resp = 1'b1; b_mem_rdata = rdata; end
        acc++;
      end
      tick();
      b_req_valid = 1'b0; b_mem_resp = 1'b0; b_mem_rdata = '0;
      #1;
    end
    req_cyc = acc;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_req_valid = 0; a_req_read = 0; a_req_write = 0; a_req_funct3 = 0;
    a_req_addr = 0; a_req_wdata = 0; a_mem_resp = 0; a_mem_rdata = 0;
    b_req_valid = 0; b_req_read = 0; b_req_write = 0; b_req_funct3 = 0;
    b_req_addr = 0; b_req_wdata = 0; b_mem_resp = 0; b_mem_rdata = 0;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    n_cmp++;
    if ({a_mem_addr, a_mem_read, a_mem_write, a_mem_wdata, a_mem_byte_enable,
         a_stall, a_ld_data, a_ld_valid, a_req_err} !== '0) begin
      n_bad++; $display("FAIL reset_a outputs not all zero: stall=%0b ld=%h addr=%h", a_stall, a_ld_data, a_mem_addr);
    end
    n_cmp++;
    if ({b_mem_addr, b_mem_read, b_mem_write, b_mem_wdata, b_mem_byte_enable,
         b_stall, b_ld_data, b_ld_valid, b_req_err} !== '0) begin
      n_bad++; $display("FAIL reset_b outputs not all zero: stall=%0b ld=%h addr=%h", b_stall, b_ld_data, b_mem_addr);
    end
  endtask

  task automatic test_lw();
    int st, lc, ec, rc, us; logic [31:0] ld, ma, mw; logic [3:0] be; logic mr, mwr;
    a_access(1, 0, 3'b010, 32'h1000, 32'h0, 3, 32'hDEADBEEF, st, lc, ec, rc, ld, ma, be, mw, mr, mwr, us);
    n_cmp++; if (ma !== 32'h1000) begin n_bad++; $display("FAIL lw_addr got %h want 00001000", ma); end
    n_cmp++; if (be !== 4'b1111) begin n_bad++; $display("FAIL lw_be got %b want 1111", be); end
    n_cmp++; if (mr !== 1'b1 || mwr !== 1'b0) begin n_bad++; $display("FAIL lw_rw got rd=%0b wr=%0b want 1/0", mr, mwr); end
    n_cmp++; if (st != 5) begin n_bad++; $display("FAIL lw_stall got %0d want 5", st); end
    n_cmp++; if (rc != 4) begin n_bad++; $display("FAIL lw_req_cycles got %0d want 4", rc); end
    n_cmp++; if (us != 0) begin n_bad++; $display("FAIL lw_held got %0d changes want 0", us); end
    n_cmp++; if (lc != 1) begin n_bad++; $display("FAIL lw_ld_pulses got %0d want 1", lc); end
    n_cmp++; if (ld !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data got %h want deadbeef", ld); end
  endtask

  task automatic test_sub_loads();
    int st, lc, ec, rc, us; logic [31:0] ld, ma, mw; logic [3:0] be; logic mr, mwr;
    a_access(1, 0, 3'b000, 32'h1003, 32'h0, 1, 32'h80FF0000, st, lc, ec, rc, ld, ma, be, mw, mr, mwr, us);
    n_cmp++; if (be !== 4'b1000) begin n_bad++; $display("FAIL lb_be got %b want 1000", be); end
    n_cmp++; if (ld !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_data got %h want ffffff80", ld); end
    n_cmp++; if (st != 3) begin n_bad++; $display("FAIL lb_stall got %0d want 3", st); end
    a_access(1, 0, 3'b100, 32'h1003, 32'h0, 0, 32'h80FF0000, st, lc, ec, rc, ld, ma, be, mw, mr, mwr, us);
    n_cmp++; if (ld !== 32'h00000080) begin n_bad++; $display("FAIL lbu_data got %h want 00000080", ld); end
    n_cmp++; if (st != 2) begin n_bad++; $display("FAIL lbu_stall got %0d want 2", st); end
    a_access(1, 0, 3'b001, 32'h1002, 32'h0, 0, 32'h80010000, st, lc, ec, rc, ld, ma, be, mw, mr, mwr, us);
    n_cmp++; if (be !== 4'b1100) begin n_bad++; $display("FAIL lh_be got %b want 1100", be); end
    n_cmp++; if (ld !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_data got %h want ffff8001", ld); end
    a_access(1, 0, 3'b101, 32'h1002, 32'h0, 0, 32'h80010000, st, lc, ec, rc, ld, ma, be, mw, mr, mwr, us);
    n_cmp++; if (ld !== 32'h00008001) begin n_bad++; $display("FAIL lhu_data got %h want 00008001", ld); end
  endtask

  task automatic test_store();
    int st, lc, ec, rc, us; logic [31:0] ld, ma, mw; logic [3:0] be; logic mr, mwr;
    a_access(0, 1, 3'b001, 32'h2002, 32'h0000ABCD, 2, 32'h0, st, lc, ec, rc, ld, ma, be, mw, mr, mwr, us);
    n_cmp++; if (mwr !== 1'b1 || mr !== 1'b0) begin n_bad++; $display("FAIL sh_rw got rd=%0b wr=%0b want 0/1", mr, mwr); end
    n_cmp++; if (ma !== 32'h2000) begin n_bad++; $display("FAIL sh_addr got %h want 00002000", ma); end
    n_cmp++; if (be !== 4'b1100) begin n_bad++; $display("FAIL sh_be got %b want 1100", be); end
    n_cmp++; if (mw !== 32'hABCD0000) begin n_bad++; $display("FAIL sh_wdata got %h want abcd0000", mw); end
    n_cmp++; if (lc != 0) begin n_bad++; $display("FAIL sh_ld_valid got %0d pulses want 0", lc); end
    n_cmp++; if (st != 4) begin n_bad++; $display("FAIL sh_stall got %0d want 4", st); end
    n_cmp++; if (us != 0) begin n_bad++; $display("FAIL sh_held got %0d changes want 0", us); end
    n_cmp++; if (a_ld_data !== 32'h00008001) begin n_bad++; $display("FAIL ld_hold got %h want 00008001", a_ld_data); end
  endtask

  task automatic test_errors();
    logic [2:0]  f3_t [5] = '{3'b010, 3'b010, 3'b110, 3'b011, 3'b001};
    logic        rd_t [5] = '{1'b0,   1'b1,   1'b1,   1'b1,   1'b1};
    logic        wr_t [5] = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0};
    logic [31:0] ad_t [5] = '{32'h3001, 32'h1000, 32'h1000, 32'h1000, 32'h1001};
    int st, lc, ec, rc, us; logic [31:0] ld, ma, mw; logic [3:0] be; logic mr, mwr;
    for (int i = 0; i < 5; i++) begin
      a_access(rd_t[i], wr_t[i], f3_t[i], ad_t[i], 32'h12345678, 0, 32'h0,
               st, lc, ec, rc, ld, ma, be, mw, mr, mwr, us);
      n_cmp++; if (ec != 1) begin n_bad++; $display("FAIL err%0d_pulses got %0d want 1", i, ec); end
      n_cmp++; if (rc != 0) begin n_bad++; $display("FAIL err%0d_mem_req got %0d cycles want 0", i, rc); end
      n_cmp++; if (st != 0) begin n_bad++; $display("FAIL err%0d_stall got %0d want 0", i, st); end
    end
  endtask

  task automatic test_wide();
    int st, lc, ec, rc; logic [63:0] ld, mw; logic [31:0] ma; logic [7:0] be; logic mwr;
    b_access(1, 0, 3'b011, 32'h4008, 64'h0, 1, 64'h0123456789ABCDEF, st, lc, ec, rc, ld, ma, be, mw, mwr);
    n_cmp++; if (ma !== 32'h4008) begin n_bad++; $display("FAIL ld64_addr got %h want 00004008", ma); end
    n_cmp++; if (be !== 8'hFF) begin n_bad++; $display("FAIL ld64_be got %h want ff", be); end
    n_cmp++; if (ld !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL ld64_data got %h want 0123456789abcdef", ld); end
    n_cmp++; if (st != 3) begin n_bad++; $display("FAIL ld64_stall got %0d want 3", st); end
    b_access(1, 0, 3'b010, 32'h400C, 64'h0, 0, 64'h8000000012345678, st, lc, ec, rc, ld, ma, be, mw, mwr);
    n_cmp++; if (ma !== 32'h4008) begin n_bad++; $display("FAIL lw64_addr got %h want 00004008", ma); end
    n_cmp++; if (be !== 8'hF0) begin n_bad++; $display("FAIL lw64_be got %h want f0", be); end
    n_cmp++; if (ld !== 64'hFFFFFFFF80000000) begin n_bad++; $display("FAIL lw64_data got %h want ffffffff80000000", ld); end
    b_access(1, 0, 3'b110, 32'h400C, 64'h0, 0, 64'h8000000012345678, st, lc, ec, rc, ld, ma, be, mw, mwr);
    n_cmp++; if (ld !== 64'h0000000080000000) begin n_bad++; $display("FAIL lwu64_data got %h want 0000000080000000", ld); end
    b_access(0, 1, 3'b000, 32'h4005, 64'h00000000000000EE, 0, 64'h0, st, lc, ec, rc, ld, ma, be, mw, mwr);
    n_cmp++; if (be !== 8'h20) begin n_bad++; $display("FAIL sb64_be got %h want 20", be); end
    n_cmp++; if (mw[47:40] !== 8'hEE || mwr !== 1'b1) begin n_bad++; $display("FAIL sb64_wdata got %h wr=%0b want byte5=ee wr=1", mw, mwr); end
    b_access(1, 0, 3'b011, 32'h4004, 64'h0, 0, 64'h0, st, lc, ec, rc, ld, ma, be, mw, mwr);
    n_cmp++; if (ec != 1 || rc != 0) begin n_bad++; $display("FAIL ld64_misalign got err=%0d req=%0d want 1/0", ec, rc); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  st_tr, rd_tr, lv_tr;
    logic [31:0] ld1, ld2;
    int          k;
    st_tr = '0; rd_tr = '0; lv_tr = '0; ld1 = '0; ld2 = '0; k = 0;
    a_req_valid = 1'b1; a_req_read = 1'b1; a_req_write = 1'b0;
    a_req_funct3 = 3'b010; a_req_addr = 32'h0000_0010;
    #1;
    for (int c = 0; c < 6; c++) begin
      st_tr = {st_tr[4:0], a_stall};
      rd_tr = {rd_tr[4:0], a_mem_read};
      lv_tr = {lv_tr[4:0], a_ld_valid};
      if (a_ld_valid) begin
        if (k == 1) ld1 = a_ld_data;
        else        ld2 = a_ld_data;
      end
      if (a_mem_read) begin
        k++;
        a_mem_resp = 1'b1;
        a_mem_rdata = (k == 1) ? 32'h11111111 : 32'h22222222;
      end
      tick();
      a_mem_resp = 1'b0; a_mem_rdata = '0;
      #1;
    end
    a_req_valid = 1'b0; a_req_read = 1'b0;
    tick();
    n_cmp++; if (st_tr !== 6'b110110) begin n_bad++; $display("FAIL b2b_stall got %b want 110110", st_tr); end
    n_cmp++; if (rd_tr !== 6'b010010) begin n_bad++; $display("FAIL b2b_mem_read got %b want 010010", rd_tr); end
    n_cmp++; if (lv_tr !== 6'b001001) begin n_bad++; $display("FAIL b2b_ld_valid got %b want 001001", lv_tr); end
    n_cmp++; if (ld1 !== 32'h11111111 || ld2 !== 32'h22222222) begin n_bad++; $display("FAIL b2b_data got %h/%h want 11111111/22222222", ld1, ld2); end
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    a_req_valid = 1'b1; a_req_read = 1'b1; a_req_write = 1'b0;
    a_req_funct3 = 3'b010; a_req_addr = 32'h5004;
    #1;
    tick();
    a_req_valid = 1'b0; a_req_read = 1'b0;
    #1;
    n_cmp++; if (a_mem_read !== 1'b1 || a_mem_addr !== 32'h5004) begin n_bad++; $display("FAIL abort_pre got rd=%0b addr=%h want 1/00005004", a_mem_read, a_mem_addr); end
    tick();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0; a_mem_resp = 1'b1; a_mem_rdata = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if ({a_mem_addr, a_mem_read, a_mem_write, a_mem_wdata, a_mem_byte_enable,
         a_stall, a_ld_data, a_ld_valid, a_req_err} !== '0) begin
      n_bad++; $display("FAIL abort_outputs not zero: rd=%0b stall=%0b ld=%h", a_mem_read, a_stall, a_ld_data);
    end
    tick();
    a_mem_resp = 1'b0; a_mem_rdata = '0;
    for (int c = 0; c < 4; c++) begin
      if (a_ld_valid || a_stall || a_mem_read || (a_ld_data !== 32'h0)) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_late_resp got %0d active cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub_loads();
    test_store();
    test_errors();
    test_wide();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
Parametrised multi-cycle successor to the pipeline MEM stage. It accepts one load/store from the EX/MEM buffer and drives a variable-latency data-memory port with a held request until the memory responds. It generates byte enables and aligned store data for any bus width, and returns a sign- or zero-extended load result. It stalls the upstream pipeline while the access is outstanding and flags misaligned or illegal accesses without touching memory.

Parameters:
DATA_W, 32, data bus width in bits; legal values are 32 or 64.
ADDR_W, 32, byte-address width.
BYTES, DATA_W/8, derived: byte lanes per beat.
LANE_W, $clog2(BYTES), derived: number of address offset bits.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  EX/MEM entry holds a memory op this cycle
req_read  in  1  operation is a load
req_write  in  1  operation is a store
req_funct3  in  3  RV funct3 (load or store encoding)
req_addr  in  ADDR_W  unaligned byte address (mar)
req_wdata  in  DATA_W  store source, unshifted
mem_addr  out  ADDR_W  req_addr with LANE_W low bits cleared
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_wdata  out  DATA_W  lane-shifted store data
mem_byte_enable  out  BYTES  active-lane mask, driven for both reads and writes
mem_resp  in  1  memory completion, one-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_resp
stall  out  1  freeze upstream stages
ld_data  out  DATA_W  extended load result
ld_valid  out  1  ld_data valid, one-cycle pulse
req_err  out  1  misaligned or illegal access, one-cycle pulse

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; all outputs 0, including ld_data and the request registers.
- Access size: sz = funct3[1:0], giving 1, 2, 4 or 8 bytes.
  - sz=3 is illegal when DATA_W=32.
  - Loads with funct3 111 are illegal; funct3 110 (lwu) is illegal when DATA_W=32.
  - Stores with funct3[2]=1 are illegal.
- Misaligned: addr[sz-1:0] != 0.
- Illegal: req_read and req_write both high.
- Lane: lane = req_addr[LANE_W-1:0].
- Byte enable: ((1<<bytes)-1) << lane.
- Store data: mem_wdata = req_wdata << (8*lane).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req_valid & (read|write) & legal: latch addr, funct3, read/write, wdata, be into registers; stall=1 combinationally this cycle; next state ACCESS.
  - req_valid & (read|write) & illegal/misaligned: req_err=1 for one cycle (registered, asserted the next cycle); no memory request; stall=0; remain IDLE.
  - No memory op: stall=0; ld_valid=0.
  - mem_resp while in IDLE is ignored.
- ACCESS:
  - mem_read/mem_write, mem_addr, mem_wdata and mem_byte_enable are driven from registers and held stable until mem_resp.
  - stall=1.
  - On mem_resp: the request deasserts the next cycle.
  - If a load, register ld_data = extend(mem_rdata >> 8*lane) using funct3 (lb/lh/lw sign-extend; lbu/lhu/lwu zero-extend; ld passes through).
  - Next state DONE.
- DONE (exactly one cycle):
  - stall=0, so the pipeline advances the completed instruction.
  - ld_valid=1 if the access was a load; ld_data is held until the next load completes.
  - Next state IDLE.
  - req_valid in DONE is not accepted; it is evaluated the following cycle in IDLE (this prevents re-issuing the same entry).
- Latency: with mem_resp arriving N cycles after the first ACCESS cycle (N≥0, resp in the same cycle allowed), stall is high for N+2 cycles and ld_valid rises N+2 cycles after acceptance.
- rst during ACCESS: abort immediately, state IDLE, requests dropped; a late mem_resp is ignored.
- Store data/enables beyond the access size: upper bytes of req_wdata are ignored; lanes outside the mask carry don't-care data.

Test Plan:
- DATA_W=32, lw addr 0x1000, mem_resp after 3 cycles with rdata 0xDEADBEEF -> mem_addr 0x1000, be 1111, stall high 5 cycles, ld_data 0xDEADBEEF, ld_valid one pulse.
- lb addr 0x1003, rdata 0x80FF_0000 -> be 1000, ld_data 0xFFFFFF80; lbu at the same address -> 0x00000080.
- sh addr 0x2002, wdata 0x0000ABCD -> mem_write, mem_addr 0x2000, be 1100, mem_wdata 0xABCD0000; ld_valid stays 0.
- sw addr 0x3001 -> req_err pulse, no mem_read/mem_write, stall never asserted.
- DATA_W=64, ld addr 0x4008 -> mem_addr 0x4008, be 0xFF; lw addr 0x400C, rdata 0x8000_0000_xxxx_xxxx -> be 0xF0, ld_data 0xFFFF_FFFF_8000_0000.
- Back-to-back loads with resp in the same cycle, plus rst asserted mid-ACCESS followed by a late mem_resp -> second load accepted only after DONE; after reset all outputs are 0 and the late resp produces no ld_valid.
